seq_add8_arb: RTL and testbench

SEQ_ADD8_ARB -- requirements
Module: seq_add8_arb

---
 rtl/seq_add8_arb_if.sv | 35 +++
 rtl/seq_add8_arb.sv | 135 +++++++++++++
 tb/tb_seq_add8_arb.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/seq_add8_arb_if.sv
// rtl/seq_add8_arb_if.sv - request/operand/result bundle for the shared 8-bit serial adder
//
// Signals:
//   req[1:0]            per-requester add request (level)
//   A0, B0 / A1, B1     operands of requester 0 / requester 1
//   gnt[1:0]            one-hot, one-cycle grant pulse
//   busy                operation in progress (grant cycle through done cycle)
//   done                one-cycle result-valid pulse
//   done_id             requester owning the current/last result
//   S[7:0], Co          sum and carry out of bit 7
// Modports: master = requester side, slave = adder block.

interface seq_add8_arb_if;
    logic [1:0] req;
    logic [7:0] A0;
    logic [7:0] B0;
    logic [7:0] A1;
    logic [7:0] B1;
    logic [1:0] gnt;
    logic       busy;
    logic       done;
    logic       done_id;
    logic [7:0] S;
    logic       Co;

    modport master (
        output req, A0, B0, A1, B1,
        input  gnt, busy, done, done_id, S, Co
    );

    modport slave (
        input  req, A0, B0, A1, B1,
        output gnt, busy, done, done_id, S, Co
    );
endinterface

// File: rtl/seq_add8_arb.sv
// rtl/seq_add8_arb.sv - two-requester round-robin arbiter around one 2-bit serial adder slice
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      seq_add8_arb_if.slave (req, A0/B0, A1/B1 in; gnt, busy, done, done_id, S, Co out)
//
// Operation: in IDLE a pending request is granted (combinational one-cycle gnt),
// the winner's operands are captured, then four ADD cycles process 2-bit slices
// LSB first through a single shared slice adder, followed by one DONE cycle.

module seq_add8_arb (
    input  logic           clk,
    input  logic           reset_n,
    seq_add8_arb_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [1:0] k;
    logic       carry;
    logic [7:0] s_q;
    logic       co_q;
    logic       owner;
    // Requester that wins a tie; flips to the other one after every grant.
    logic       prio;

    logic       win;
    logic       grant_en;
    logic [1:0] a_sl;
    logic [1:0] b_sl;
    logic [2:0] sl_sum;

    // A lone request wins outright; a tie goes to the prio holder.
    always_comb begin
        win = prio;
        if (bus.req == 2'b01) begin
            win = 1'b0;
        end else if (bus.req == 2'b10) begin
            win = 1'b1;
        end
    end

    // The one shared 2-bit slice adder.
    always_comb begin
        a_sl   = op_a[{k, 1'b0} +: 2];
        b_sl   = op_b[{k, 1'b0} +: 2];
        sl_sum = {1'b0, a_sl} + {1'b0, b_sl} + {2'b00, carry};
    end

    always_comb begin
        state_nxt = state;
        grant_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req != 2'b00) begin
                    grant_en  = 1'b1;
                    state_nxt = ST_ADD;
                end
            end
            ST_ADD: begin
                if (k == 2'd3) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // gnt is a Mealy output of IDLE; it is masked while reset is held so that
    // a level request during reset produces no grant pulse.
    always_comb begin
        bus.gnt = 2'b00;
        if (grant_en && reset_n) begin
            bus.gnt = win ? 2'b10 : 2'b01;
        end
        bus.busy    = (state != ST_IDLE) || (grant_en && reset_n);
        bus.done    = (state == ST_DONE);
        bus.done_id = owner;
        bus.S       = s_q;
        bus.Co      = co_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_a  <= 8'h00;
            op_b  <= 8'h00;
            k     <= 2'd0;
            carry <= 1'b0;
            s_q   <= 8'h00;
            co_q  <= 1'b0;
            owner <= 1'b0;
            prio  <= 1'b0;
        end else begin
            if (grant_en) begin
                op_a  <= win ? bus.A1 : bus.A0;
                op_b  <= win ? bus.B1 : bus.B0;
                k     <= 2'd0;
                carry <= 1'b0;
                owner <= win;
                prio  <= ~win;
            end else if (state == ST_ADD) begin
                s_q[{k, 1'b0} +: 2] <= sl_sum[1:0];
                carry               <= sl_sum[2];
                k                   <= k + 2'd1;
                if (k == 2'd3) begin
                    co_q <= sl_sum[2];
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_add8_arb.sv
// tb/tb_seq_add8_arb.sv - self-checking random bench for seq_add8_arb

module tb_seq_add8_arb;

    logic clk;
    logic reset_n;
    int   cyc;
    int   total;
    int   bad;
    int   rr_pref;     // model: requester that wins a tie

    seq_add8_arb_if bus ();

    seq_add8_arb dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, obs, obs, exp, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [1:0] r);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
        return rr_pref;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete operation; called one time unit after a rising edge while the
    // DUT is idle. Returns one time unit into the cycle after done.
    task automatic do_op(input logic [1:0] r, input logic [7:0] a0, input logic [7:0] b0,
                         input logic [7:0] a1, input logic [7:0] b1,
                         input bit hold, input bit scramble, output int gcyc);
        int       w;
        int       lat;
        logic [8:0] exp_sum;
        bus.req = r;
        bus.A0  = a0;
        bus.B0  = b0;
        bus.A1  = a1;
        bus.B1  = b1;
        #1;
        w = pick(r);
        chk("gnt", int'(bus.gnt), (w == 1) ? 2 : 1);
        chk("busy_gnt", int'(bus.busy), 1);
        chk("done_gnt", int'(bus.done), 0);
        exp_sum = (w == 1) ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
        rr_pref = (w == 1) ? 0 : 1;
        gcyc = cyc;
        step();
        if (!hold) bus.req = 2'b00;
        if (scramble) begin
            bus.A0 = 8'($urandom);
            bus.B0 = 8'($urandom);
            bus.A1 = 8'($urandom);
            bus.B1 = 8'($urandom);
        end
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            #1;
            if (bus.done) begin
                lat = i;
                break;
            end
            chk("busy_add", int'(bus.busy), 1);
            chk("gnt_add", int'(bus.gnt), 0);
            step();
        end
        chk("latency", lat, 5);
        chk("S", int'(bus.S), int'(exp_sum[7:0]));
        chk("Co", int'(bus.Co), int'(exp_sum[8]));
        chk("done_id", int'(bus.done_id), w);
        chk("busy_done", int'(bus.busy), 1);
        step();
        if (!hold) begin
            #1;
            chk("done_clr", int'(bus.done), 0);
            chk("busy_idle", int'(bus.busy), 0);
            chk("gnt_idle", int'(bus.gnt), 0);
            chk("S_hold", int'(bus.S), int'(exp_sum[7:0]));
            chk("Co_hold", int'(bus.Co), int'(exp_sum[8]));
            chk("id_hold", int'(bus.done_id), w);
        end
    endtask

    initial begin
        int g;
        int prev_g;
        logic [1:0] r;
        total   = 0;
        bad     = 0;
        cyc     = 0;
        rr_pref = 0;
        reset_n = 1'b0;
        bus.req = 2'b11;
        bus.A0  = 8'h5A;
        bus.B0  = 8'hA5;
        bus.A1  = 8'h33;
        bus.B1  = 8'hCC;
        step();
        step();
        chk("rst_gnt", int'(bus.gnt), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_id", int'(bus.done_id), 0);
        chk("rst_S", int'(bus.S), 0);
        chk("rst_Co", int'(bus.Co), 0);
        bus.req = 2'b00;
        reset_n = 1'b1;
        step();

        // overflow into Co
        do_op(2'b01, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, g);

        // fresh reset, simultaneous requests: 0 first, then 1 right after done
        reset_n = 1'b0;
        rr_pref = 0;
        step();
        reset_n = 1'b1;
        do_op(2'b11, 8'h12, 8'h34, 8'hAA, 8'h55, 1'b1, 1'b0, prev_g);
        do_op(2'b11, 8'h12, 8'h34, 8'hAA, 8'h55, 1'b0, 1'b0, g);
        chk("spacing_pair", g - prev_g, 6);

        // four back-to-back held requests: alternation and exact spacing
        for (int i = 0; i < 4; i++) begin
            do_op(2'b11, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  (i < 3), 1'b0, g);
            if (i > 0) chk("spacing_hold", g - prev_g, 6);
            prev_g = g;
        end

        // operands change after capture
        do_op(2'b01, 8'h80, 8'h80, 8'h00, 8'h00, 1'b0, 1'b1, g);

        // reset two cycles into an operation aborts it
        bus.req = 2'b10;
        bus.A1  = 8'h77;
        bus.B1  = 8'h11;
        #1;
        chk("gnt_abort", int'(bus.gnt), (pick(2'b10) == 1) ? 2 : 1);
        step();
        bus.req = 2'b00;
        step();
        reset_n = 1'b0;
        #1;
        rr_pref = 0;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_S", int'(bus.S), 0);
        chk("abort_Co", int'(bus.Co), 0);
        chk("abort_id", int'(bus.done_id), 0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("abort_nodone", int'(bus.done), 0);
            step();
        end
        do_op(2'b10, 8'h00, 8'h00, 8'h9C, 8'h64, 1'b0, 1'b0, g);

        // random sweep
        for (int i = 0; i < 1000; i++) begin
            r = 2'($urandom_range(1, 3));
            do_op(r, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) == 0), 1'($urandom), g);
        end
        bus.req = 2'b00;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
